// File: rtl/region_scheduler.sv
// region_scheduler: steps one message counter through cfg_count consecutive regions starting at cfg_base.
module region_scheduler #(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_base,
  input  logic [CW-1:0] cfg_count,
  input  logic          abort,
  input  logic          fifo_almost_full,
  output logic          ctr_start,
  output logic          ctr_pause,
  output logic          ctr_reset_counter,
  output logic [N-1:0]  ctr_region_select,
  input  logic          ctr_done,
  output logic          region_done,
  output logic [CW-1:0] regions_done,
  output logic          busy,
  output logic          all_done,
  output logic          aborted
);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, CLEAR, ABORT1, ABORT2, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic active;
  assign active = state inside {LOAD, START, RUN, CLEAR};
  // regions_done doubles as the region index: it is cleared on accept and advances with each region
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state             <= IDLE;
      count             <= '0;
      ctr_region_select <= '0;
      regions_done      <= '0;
      aborted           <= 1'b0;
    end else if (cfg_ready && cfg_valid) begin
      count        <= cfg_count;
      regions_done <= '0;
      aborted      <= 1'b0;
      if (cfg_count != '0) ctr_region_select <= cfg_base;
      state <= (cfg_count != '0) ? LOAD : DONE;
    end else if (active && abort) begin
      state   <= ABORT1;
      aborted <= 1'b1;
    end else
      case (state)
        LOAD:   state <= START;
        START:  state <= RUN;
        RUN:    state <= ctr_done ? CLEAR : RUN;
        CLEAR: begin
          regions_done <= regions_done + CW'(1);
          if (regions_done + CW'(1) == count) state <= DONE;
          else begin
            state             <= LOAD;
            ctr_region_select <= ctr_region_select + N'(1);
          end
        end
        ABORT1: state <= ABORT2;
        ABORT2: state <= IDLE;
        default: ;
      endcase
  assign cfg_ready         = (state == IDLE) || (state == DONE);
  assign busy              = !cfg_ready;
  assign all_done          = state == DONE;
  assign ctr_start         = state == START;
  assign region_done       = state == CLEAR;
  // the counter's pause outranks its reset, so pause is only ever relayed in RUN
  assign ctr_reset_counter = state inside {CLEAR, ABORT1, ABORT2};
  assign ctr_pause         = (state == RUN) && fifo_almost_full;
endmodule

// File: tb/tb_region_scheduler.sv
// tb_region_scheduler: directed and randomized jobs checked against a cycle-timing model of the scheduler.
module tb_region_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready;
  logic [31:0] cfg_base = '0;
  logic [7:0] cfg_count = '0;
  logic abort = 1'b0, fifo_almost_full = 1'b0;
  logic ctr_start, ctr_pause, ctr_reset_counter;
  logic [31:0] ctr_region_select;
  logic ctr_done = 1'b0;
  logic region_done;
  logic [7:0] regions_done;
  logic busy, all_done, aborted;
  int n_checks = 0, n_fails = 0, pulses = 0;

  region_scheduler #(.N(32), .CW(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base(cfg_base), .cfg_count(cfg_count), .abort(abort),
    .fifo_almost_full(fifo_almost_full), .ctr_start(ctr_start), .ctr_pause(ctr_pause),
    .ctr_reset_counter(ctr_reset_counter), .ctr_region_select(ctr_region_select),
    .ctr_done(ctr_done), .region_done(region_done), .regions_done(regions_done),
    .busy(busy), .all_done(all_done), .aborted(aborted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (region_done) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_abort_cycle(input string tag, input logic [7:0] rd);
    fifo_almost_full = 1'b1;
    #1;
    chk({tag, "_reset"}, ctr_reset_counter, 1);
    chk({tag, "_pause"}, ctr_pause, 0);
    chk({tag, "_start"}, ctr_start, 0);
    chk({tag, "_rdone_pulse"}, region_done, 0);
    chk({tag, "_aborted"}, aborted, 1);
    chk({tag, "_regions_done"}, regions_done, rd);
    fifo_almost_full = 1'b0;
  endtask

  // abort_mode 0: abort in START of region abort_at; 1: abort together with ctr_done in RUN
  task automatic run_job(input logic [31:0] base, input logic [7:0] cnt,
                         input int abort_at, input int abort_mode);
    logic [31:0] region;
    int p0;
    chk("ready_before_accept", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_base = base; cfg_count = cnt;
    tick();
    cfg_valid = 1'b0; cfg_base = $urandom; cfg_count = 8'($urandom);
    if (cnt == 0) begin
      chk("cnt0_all_done", all_done, 1);
      chk("cnt0_no_start", ctr_start, 0);
      chk("cnt0_regions_done", regions_done, 0);
      chk("cnt0_aborted", aborted, 0);
      chk("cnt0_ready", cfg_ready, 1);
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      region = base + 32'(i);
      chk("load_region", ctr_region_select, region);
      chk("load_no_start", ctr_start, 0);
      chk("load_busy", busy, 1);
      chk("load_aborted", aborted, 0);
      chk("load_regions_done", regions_done, i);
      tick();
      chk("start_pulse", ctr_start, 1);
      chk("start_region", ctr_region_select, region);
      if (i == abort_at && abort_mode == 0) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_abort_cycle("abort1", 8'(i));
        tick();
        check_abort_cycle("abort2", 8'(i));
        tick();
        chk("abort_idle_ready", cfg_ready, 1);
        chk("abort_idle_all_done", all_done, 0);
        chk("abort_idle_aborted", aborted, 1);
        return;
      end
      tick();
      for (int d = $urandom_range(0, 4); d >= 0; d--) begin
        fifo_almost_full = 1'($urandom);
        ctr_done = (d == 0);
        #1;
        chk("run_pause_mirror", ctr_pause, fifo_almost_full);
        chk("run_no_start", ctr_start, 0);
        chk("run_no_reset", ctr_reset_counter, 0);
        if (d > 0) tick();
      end
      p0 = pulses;
      if (i == abort_at && abort_mode == 1) begin
        abort = 1'b1;
        tick();
        abort = 1'b0; ctr_done = 1'b0;
        check_abort_cycle("done_abort1", 8'(i));
        tick();
        check_abort_cycle("done_abort2", 8'(i));
        chk("done_abort_no_pulse", pulses, p0);
        tick();
        chk("done_abort_ready", cfg_ready, 1);
        return;
      end
      tick();
      ctr_done = 1'b0; fifo_almost_full = 1'b1;
      #1;
      chk("clear_reset", ctr_reset_counter, 1);
      chk("clear_pulse", region_done, 1);
      chk("clear_pause_forced", ctr_pause, 0);
      fifo_almost_full = 1'b0;
      tick();
      chk("after_clear_regions_done", regions_done, i + 1);
      chk("after_clear_reset_low", ctr_reset_counter, 0);
      chk("pulse_count", pulses, p0 + 1);
    end
    chk("job_all_done", all_done, 1);
    chk("job_ready", cfg_ready, 1);
    chk("job_not_busy", busy, 0);
  endtask

  initial begin
    #2;
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_region", ctr_region_select, 0);
    chk("rst_regions_done", regions_done, 0);
    chk("rst_outputs", {ctr_start, ctr_pause, ctr_reset_counter, region_done, all_done, aborted}, 0);
    #10 rst = 1'b0;
    tick();
    run_job(32'h0000_0005, 8'd1, -1, 0);
    pulses = 0;
    run_job(32'hFFFF_FFFE, 8'd3, -1, 0);
    chk("wrap_pulses", pulses, 3);
    chk("wrap_last_region", ctr_region_select, 32'h0000_0000);
    run_job(32'h1234_0000, 8'd0, -1, 0);
    run_job($urandom, 8'd3, 0, 0);
    run_job($urandom, 8'd4, 1, 1);
    run_job($urandom, 8'd0, -1, 0);
    run_job(32'hFFFF_FFFF, 8'd2, -1, 0);
    for (int j = 0; j < 8; j++)
      run_job($urandom, 8'($urandom_range(1, 4)), $urandom_range(0, 5), $urandom_range(0, 1));
    cfg_valid = 1'b1; cfg_base = 32'hABCD_0000; cfg_count = 8'd2;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    fifo_almost_full = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", cfg_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_region", ctr_region_select, 0);
    chk("arst_outputs", {ctr_start, ctr_pause, ctr_reset_counter, region_done, all_done, aborted}, 0);
    #1 rst = 1'b0; fifo_almost_full = 1'b0;
    tick();
    chk("arst_release_ready", cfg_ready, 1);
    run_job(32'h0000_0010, 8'd2, -1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/region_scheduler.md
# region_scheduler

Sequences one `message_counter_partial` instance through a contiguous run of regions. Regions run from `cfg_base` to `cfg_base + cfg_count - 1`, modulo 2^N. The block sits between the host/config interface and the counter. For each region it loads the region select, starts the counter, relays downstream back-pressure as pause, waits for `done`, then clears the counter. It reports per-region and overall completion, and supports abort at any point.

## Interface
Parameters:
- `N`, 32: region-select width; must match the counter's `N`.
- `CW`, 8: width of the region count and progress counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  job request.
- `cfg_ready`  out  1  high in IDLE and DONE; job accepted when `cfg_valid & cfg_ready`.
- `cfg_base`  in  N  first region, sampled on accept.
- `cfg_count`  in  CW  number of regions, sampled on accept; 0 is legal.
- `abort`  in  1  level; cancels the job.
- `fifo_almost_full`  in  1  downstream back-pressure.
- `ctr_start`  out  1  to counter `start`.
- `ctr_pause`  out  1  to counter `pause`.
- `ctr_reset_counter`  out  1  to counter `reset_counter`.
- `ctr_region_select`  out  N  to counter `region_select`; registered.
- `ctr_done`  in  1  from counter `done`.
- `region_done`  out  1  one-cycle pulse per completed region.
- `regions_done`  out  CW  completed regions in the current job.
- `busy`  out  1  state not IDLE/DONE.
- `all_done`  out  1  level in DONE.
- `aborted`  out  1  sticky; set on abort, cleared on next accept.

## Operation
- Moore FSM with states IDLE, LOAD, START, RUN, CLEAR, ABORT1, ABORT2, DONE. Control outputs decode from state only.
- **IDLE / DONE:**
  - On accept: latch base, count and idx=0; clear `regions_done` and `aborted`.
  - Next state is LOAD if count≠0, else DONE.
  - In DONE, `all_done`=1 until the next accept.
- **LOAD (1 cycle):**
  - `ctr_region_select` holds base+idx, truncated to N bits; wrap is legal.
  - The register is updated on the edge entering LOAD.
  - The counter sits in init and samples the region every cycle.
- **START (1 cycle):** `ctr_start`=1. Go to RUN.
- **RUN:**
  - `ctr_pause`=`fifo_almost_full`; 0 in every other state.
  - Stay while `ctr_done`=0. On `ctr_done`=1 go to CLEAR.
- **CLEAR (1 cycle):**
  - `ctr_reset_counter`=1 and `region_done`=1.
  - `regions_done`+1 and idx+1 on exit.
  - Go to DONE if idx+1==count, else LOAD.
- **Abort:**
  - `abort`=1 in LOAD, START, RUN or CLEAR goes to ABORT1, then ABORT2, then IDLE.
  - In both ABORT states: `ctr_reset_counter`=1, `ctr_pause`=0, `ctr_start`=0.
  - Two cycles are required: the counter's first state ignores reset, so first→working→init needs two reset cycles.
  - `aborted` is set on entry to ABORT1. `regions_done` holds its value.
  - `abort` in IDLE, DONE or ABORT states is ignored.
- **Priority:**
  - `abort` beats `ctr_done` in the same RUN cycle; no `region_done` pulse.
  - `ctr_pause` is forced 0 whenever `ctr_reset_counter`=1, because the counter's pause has priority over reset.
- **Reset values:** state IDLE; `cfg_ready`=1; every other output 0, including `ctr_region_select` and `regions_done`.

## Timing
- Accept edge E0: LOAD in cycle E0+1, `ctr_start` in cycle E0+2.
- Counter reaches first at E0+3 and working at E0+4.
- `ctr_done` first seen in RUN cycle k: CLEAR at k+1, LOAD at k+2, next `ctr_start` at k+3.
- Overhead is 3 cycles per region boundary.
- `regions_done` updates on the edge leaving CLEAR and is visible the same cycle DONE/LOAD is entered.
- `cfg_ready` is combinational from state. Back-to-back jobs are allowed: accept in the first DONE cycle goes to LOAD next cycle.
- Async `rst` mid-job forces IDLE immediately. The counter's own synchronous `rst_n` must be driven from the same reset source.

## Test plan
- **Single region:** base=0x0000_0005, count=1, N=32, counter mid-range stubbed via done model.
  - Required: `ctr_region_select`=5 during LOAD/START; `ctr_start` high exactly 1 cycle at E0+2.
  - Required: after `ctr_done`, 1-cycle `ctr_reset_counter`, `regions_done`=1, `all_done`=1.
- **Wrap:** base=0xFFFF_FFFE, count=3.
  - Required: regions 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 in order; 3 `region_done` pulses; `regions_done`=3.
- **Back-pressure:** toggle `fifo_almost_full` during RUN.
  - Required: `ctr_pause` mirrors it same cycle in RUN only; forced 0 during CLEAR; counter never stuck in paused.
- **Abort:** assert `abort` in the START cycle.
  - Required: ABORT1/ABORT2 each give `ctr_reset_counter`=1 with `ctr_pause`=0; counter back in init, `valid`=0, by cycle 3; `aborted`=1; `regions_done` unchanged.
  - Repeat with abort coincident with `ctr_done`: no `region_done` pulse.
- **count=0:** accept goes straight to DONE next cycle, with no `ctr_start`.
  - Then a second job is accepted while in DONE: `aborted` and `regions_done` clear; LOAD follows.
- **Async reset:** assert `rst` mid-RUN.
  - Required: all outputs at reset values immediately; `cfg_ready`=1 after release.
